// File: rtl/add_serial_seq.sv
// rtl/add_serial_seq.sv - multi-cycle adder reusing one 2-bit ripple-carry slice
// Operands shift out two bits per RUN cycle; the carry between slices is held in creg_q.

module add_rca_2_bit (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    input  logic       c_i,
    output logic [1:0] s_o,
    output logic       c_o
);
    logic c1;

    assign s_o[0] = a_i[0] ^ b_i[0] ^ c_i;
    assign c1     = (a_i[0] & b_i[0]) | (c_i & (a_i[0] ^ b_i[0]));
    assign s_o[1] = a_i[1] ^ b_i[1] ^ c1;
    assign c_o    = (a_i[1] & b_i[1]) | (c1 & (a_i[1] ^ b_i[1]));
endmodule

module add_serial_seq #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH/2) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             zero
);
    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("add_serial_seq: WIDTH must be even and >= 2");
        end
        if (CW != $clog2(WIDTH/2) + 1) begin : g_bad_cw
            $error("add_serial_seq: CW is derived from WIDTH and must not be overridden");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH/2 - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d, ys_q, ys_d, acc_q, acc_d, sum_q, sum_d;
    logic [CW-1:0]    step_q, step_d;
    logic             creg_q, creg_d, co_q, co_d, zero_q, zero_d;

    logic [1:0]       slice_sum;
    logic             slice_co;
    logic [WIDTH-1:0] acc_shift;

    add_rca_2_bit u_slice (
        .a_i (xs_q[1:0]),
        .b_i (ys_q[1:0]),
        .c_i (creg_q),
        .s_o (slice_sum),
        .c_o (slice_co)
    );

    // New pair enters at the top so the first (least-significant) pair ends at the bottom.
    generate
        if (WIDTH == 2) begin : g_acc_narrow
            assign acc_shift = slice_sum;
        end else begin : g_acc_wide
            assign acc_shift = {slice_sum, acc_q[WIDTH-1:2]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            step_q  <= '0;
            creg_q  <= 1'b0;
            co_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            step_q  <= step_d;
            creg_q  <= creg_d;
            co_q    <= co_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        step_d  = step_q;
        creg_d  = creg_q;
        co_d    = co_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xs_d    = X;
                    ys_d    = Y;
                    creg_d  = ci;
                    step_d  = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                xs_d   = xs_q >> 2;
                ys_d   = ys_q >> 2;
                acc_d  = acc_shift;
                creg_d = slice_co;
                step_d = step_q + CW'(1);
                if (step_q == LAST_STEP) begin
                    state_d = S_DONE;
                    sum_d   = acc_shift;
                    co_d    = slice_co;
                    zero_d  = (acc_shift == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign co   = co_q;
    assign zero = zero_q;
endmodule

// File: tb/tb_add_serial_seq.sv
// tb/tb_add_serial_seq.sv - scoreboard bench for add_serial_seq at WIDTH=16 and WIDTH=2

module tb_add_serial_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start2 = 1'b0;
    logic [15:0] X = '0, Y = '0;
    logic [1:0]  X2 = '0, Y2 = '0;
    logic        ci = 1'b0, ci2 = 1'b0;
    logic        busy, done, co, zero;
    logic [15:0] sum;
    logic        busy2, done2, co2, zero2;
    logic [1:0]  sum2;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int done2_cnt = 0;
    logic [16:0] sb_q[$];
    logic [2:0]  sb2_q[$];

    always #5 clk = ~clk;

    add_serial_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y), .ci(ci),
        .busy(busy), .done(done), .sum(sum), .co(co), .zero(zero)
    );

    add_serial_seq #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .X(X2), .Y(Y2), .ci(ci2),
        .busy(busy2), .done(done2), .sum(sum2), .co(co2), .zero(zero2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            logic [16:0] e;
            done_cnt++;
            chk("sb_nonempty", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_sum", sum, e[15:0]);
                chk("sb_co", co, e[16]);
                chk("sb_zero", zero, e[15:0] == 16'h0);
            end
        end
        if (done2) begin
            logic [2:0] e2;
            done2_cnt++;
            chk("sb2_nonempty", sb2_q.size(), 1);
            if (sb2_q.size() > 0) begin
                e2 = sb2_q.pop_front();
                chk("sb2_sum", sum2, e2[1:0]);
                chk("sb2_co", co2, e2[2]);
                chk("sb2_zero", zero2, e2[1:0] == 2'h0);
            end
        end
    end

    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic c,
                         output int done_at, output int busy_cnt, output bit held);
        int guard;
        logic [15:0] s0;
        guard = 0;
        while (busy && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("idle_wait", busy, 0);
        X = x; Y = y; ci = c; start = 1'b1;
        sb_q.push_back({1'b0, x} + {1'b0, y} + {16'h0, c});
        @(posedge clk); #1;
        start = 1'b0;
        X = $urandom; Y = $urandom; ci = $urandom;
        s0 = sum; held = 1'b1; done_at = 0; busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (!busy) break;
            busy_cnt++;
            if (done && done_at == 0) done_at = k;
            if (!done && sum !== s0) held = 1'b0;
        end
    endtask

    initial begin
        int da, bc, dc;
        bit hl;
        logic [15:0] rx, ry;
        logic rc;

        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_co", co, 0);
        chk("rst_zero", zero, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        do_op(16'h1234, 16'h4321, 1'b0, da, bc, hl);
        chk("t1_latency", da, 8);
        chk("t1_busy_cycles", bc, 9);
        chk("t1_sum", sum, 16'h5555);
        chk("t1_co", co, 0);
        chk("t1_zero", zero, 0);

        do_op(16'hFFFF, 16'h0001, 1'b0, da, bc, hl);
        chk("t2a_sum", sum, 16'h0000);
        chk("t2a_co", co, 1);
        chk("t2a_zero", zero, 1);
        do_op(16'hFFFF, 16'h0000, 1'b1, da, bc, hl);
        chk("t2b_sum", sum, 16'h0000);
        chk("t2b_co", co, 1);
        chk("t2b_zero", zero, 1);

        // start re-pulsed during RUN and during DONE must be ignored
        dc = done_cnt;
        X = 16'h00FF; Y = 16'h0001; ci = 1'b0; start = 1'b1;
        sb_q.push_back(17'h00100);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 40; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin
                X = 16'hAAAA; Y = 16'h5555; start = 1'b1;
            end else if (k == 4) begin
                start = 1'b0;
            end
            if (done) begin
                X = 16'hAAAA; Y = 16'h5555; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                break;
            end
        end
        repeat (12) @(posedge clk);
        #1;
        chk("t3_single_done", done_cnt - dc, 1);
        chk("t3_idle", busy, 0);
        chk("t3_sum", sum, 16'h0100);
        chk("t3_co", co, 0);

        // asynchronous reset mid-operation
        dc = done_cnt;
        X = 16'h8000; Y = 16'h8000; ci = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("t4_pre_rst_sum", sum, 16'h0100);
        rst = 1'b1;
        #1;
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_done", done, 0);
        chk("t4_rst_sum", sum, 0);
        chk("t4_rst_co", co, 0);
        chk("t4_rst_zero", zero, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("t4_no_done", done_cnt - dc, 0);
        do_op(16'h8000, 16'h8000, 1'b0, da, bc, hl);
        chk("t4_sum", sum, 16'h0000);
        chk("t4_co", co, 1);
        chk("t4_zero", zero, 1);

        // back-to-back: next start in the IDLE cycle right after DONE
        do_op(16'h0001, 16'h0002, 1'b1, da, bc, hl);
        chk("t5_latency", da, 8);
        chk("t5_prev_held", hl, 1);
        chk("t5_sum", sum, 16'h0004);
        chk("t5_co", co, 0);

        // WIDTH=2 instance
        X2 = 2'd3; Y2 = 2'd3; ci2 = 1'b1; start2 = 1'b1;
        sb2_q.push_back(3'd7);
        @(posedge clk); #1;
        start2 = 1'b0;
        da = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (done2) begin
                da = k;
                break;
            end
        end
        chk("w2_latency", da, 1);
        @(posedge clk); #1;
        chk("w2_sum", sum2, 2'd3);
        chk("w2_co", co2, 1);
        chk("w2_idle", busy2, 0);

        for (int i = 0; i < 1000; i++) begin
            rx = $urandom; ry = $urandom; rc = $urandom;
            do_op(rx, ry, rc, da, bc, hl);
            if (i < 20) begin
                chk("rnd_latency", da, 8);
                chk("rnd_held", hl, 1);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        chk("sb2_drained", sb2_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/add_serial_seq.md
Name: add_serial_seq

Overview:
- Multi-cycle N-bit adder controller.
- Time-multiplexes one 2-bit ripple-carry slice (add_rca_2_bit) across WIDTH/2 cycles.
- Sequences operand shifting, holds the inter-slice carry in a register, and presents the result with a start/done handshake.
- Gives a low-area alternative to a full-width RCA for lab datapaths that accept multi-cycle latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be even and >= 2 (elaboration error otherwise).
- CW, $clog2(WIDTH/2)+1, step-counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- X  input  WIDTH  operand A; captured on an accepted start.
- Y  input  WIDTH  operand B; captured on an accepted start.
- ci  input  1  carry-in; captured on an accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when sum/co/zero become valid.
- sum  output  WIDTH  result; held until the next accepted start's completion.
- co  output  1  carry-out of bit WIDTH-1.
- zero  output  1  high when sum == 0; valid with sum.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, busy=0, done=0, sum=0, co=0, zero=0.
  - Operand shift registers, carry register and step counter are all cleared.
  - An in-flight operation is discarded; no done is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at a clock edge:
    - Xs<=X, Ys<=Y, creg<=ci, step<=0, acc<=0.
    - Go to RUN.
  - start=0: remain in IDLE.
- RUN (one slice operation per cycle):
  - Slice inputs: X=Xs[1:0], Y=Ys[1:0], ci=creg.
  - On the clock edge:
    - Xs and Ys shift right by 2 with zero fill.
    - acc <= {slice_sum, acc[WIDTH-1:2]}, so the least-significant pair lands at the bottom after the final step.
    - creg <= slice_co; step <= step+1.
  - When step == WIDTH/2-1 at the edge, go to DONE. On that same edge:
    - sum <= final acc value (including the current slice_sum).
    - co <= slice_co.
    - zero <= (final acc == 0).
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - start in DONE is ignored; no queuing.
- Timing:
  - Latency: start accepted at edge E0; done high in the cycle after edge E(WIDTH/2).
  - 16-bit case: RUN occupies 8 cycles, done asserts 9 cycles after start.
  - Throughput: one operation per WIDTH/2+2 cycles. The next start is accepted in the IDLE cycle following DONE.
- start while busy: ignored entirely. Operands, result and state are unaffected.
- Outputs sum/co/zero change only on the RUN->DONE edge or on reset. They are stable throughout IDLE and RUN.
- Arithmetic: unsigned modulo 2^WIDTH; co is the true carry out. X/Y changing after capture has no effect.
- WIDTH=2: RUN lasts 1 cycle; behaviour otherwise identical.
- Only one slice instance is permitted; no full-width adder may be inferred.

Test Plan:
- WIDTH=16, X=0x1234, Y=0x4321, ci=0, start pulse -> done exactly 9 cycles later; sum=0x5555, co=0, zero=0; busy high for 9 cycles.
- X=0xFFFF, Y=0x0001, ci=0 -> sum=0x0000, co=1, zero=1. Then X=0xFFFF, Y=0x0000, ci=1 -> sum=0x0000, co=1, zero=1.
- start at 0x00FF+0x0001, then start re-pulsed with X=0xAAAA, Y=0x5555 during RUN and during DONE -> single done; sum=0x0100, co=0; no second done.
- Assert rst at step 4 of 0x8000+0x8000 -> all outputs 0 immediately (async); no done. A new start 0x8000+0x8000 after release -> sum=0x0000, co=1, zero=1.
- Back-to-back: start again in the IDLE cycle right after done, with 0x0001+0x0002 ci=1 -> accepted; sum=0x0004, co=0. The previous sum holds until the new done.
- WIDTH=2 instance: X=3, Y=3, ci=1 -> done 2 cycles after start; sum=3, co=1. Plus a randomized 1000-vector compare against X+Y+ci for WIDTH=16.
